// File: rtl/sweep_ctrl_pkg.sv
// Shared types and counter pin polarities for the sweep sequencer.
package sweep_ctrl_pkg;
  localparam int SW_WIDTH = 8;
  localparam int SW_LAPW  = 4;

  // updn_cntr pin polarities
  localparam logic LOAD_ACT = 1'b0;
  localparam logic SRST_ACT = 1'b1;

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, CLR, FIN} state_t;

  typedef struct packed {
    logic [SW_WIDTH-1:0] lo;
    logic [SW_WIDTH-1:0] hi;
    logic [SW_LAPW-1:0]  laps;
  } sweep_cmd_t;

  function automatic logic [SW_LAPW-1:0] norm_laps(input logic [SW_LAPW-1:0] l);
    return (l == '0) ? SW_LAPW'(1) : l;
  endfunction
endpackage

// File: rtl/sweep_ctrl.sv
// Sweep sequencer driving updn_cntr: load lo, count lo->hi->lo for N laps, pulse done.
// Optional SWEEP_PAUSE_EN adds a pause input that freezes UP/DOWN progress.
module sweep_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int LAPW  = SW_LAPW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [LAPW-1:0]  cmd_laps,
  input  logic             abort,
`ifdef SWEEP_PAUSE_EN
  input  logic             pause,
`endif
  output logic             done,
  output logic             err,
  input  logic [WIDTH-1:0] cnt_out,
  output logic [WIDTH-1:0] cnt_in,
  output logic             up_dn,
  output logic             ena,
  output logic             cnt_load,
  output logic             s_reset
);

  state_t           r_state;
  sweep_cmd_t       r_cmd;
  logic [LAPW-1:0]  r_laps_left;
  logic             w_pause;

`ifdef SWEEP_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Counter pins decode state + cnt_out so the turnaround lands on the same edge.
  always_comb begin
    ena      = 1'b0;
    up_dn    = 1'b1;
    cnt_load = ~LOAD_ACT;
    s_reset  = ~SRST_ACT;
    cnt_in   = r_cmd.lo;
    case (r_state)
      LOAD: begin
        cnt_load = LOAD_ACT;
        ena      = 1'b1;
      end
      UP: if (!w_pause) begin
        ena   = 1'b1;
        up_dn = (cnt_out != r_cmd.hi);
      end
      DOWN: if (!w_pause) begin
        if (cnt_out != r_cmd.lo) begin
          ena   = 1'b1;
          up_dn = 1'b0;
        end else if (r_laps_left != LAPW'(1)) begin
          ena = 1'b1;
        end
      end
      CLR:     s_reset = SRST_ACT;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_laps_left <= '0;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_cmd       <= '{lo: cmd_lo, hi: cmd_hi, laps: cmd_laps};
          r_laps_left <= norm_laps(cmd_laps);
          cmd_ready   <= 1'b0;
          // An empty or inverted range never touches the counter.
          if (cmd_lo >= cmd_hi) begin
            r_state <= FIN;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            r_state <= LOAD;
          end
        end
        LOAD: r_state <= abort ? CLR : UP;
        UP: begin
          if (abort)                                r_state <= CLR;
          else if (!w_pause && cnt_out == r_cmd.hi) r_state <= DOWN;
        end
        DOWN: begin
          if (abort) begin
            r_state <= CLR;
          end else if (!w_pause && cnt_out == r_cmd.lo) begin
            r_laps_left <= r_laps_left - LAPW'(1);
            if (r_laps_left == LAPW'(1)) begin
              r_state <= FIN;
              done    <= 1'b1;
            end else begin
              r_state <= UP;
            end
          end
        end
        CLR: begin
          r_state <= FIN;
          done    <= 1'b1;
          err     <= 1'b1;
        end
        FIN: begin
          r_state   <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Randomized bench for sweep_ctrl with a behavioural updn_cntr stand-in and a
// triangle-wave reference model of the expected counter trace.
module tb_sweep_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_lo = '0, cmd_hi = '0;
  logic [3:0] cmd_laps = '0;
  logic       abort = 1'b0;
`ifdef SWEEP_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       done, err, up_dn, ena, cnt_load, s_reset;
  logic [7:0] cnt_out, cnt_in;

  int n_chk = 0, n_pass = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  sweep_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi), .cmd_laps(cmd_laps), .abort(abort),
`ifdef SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .done(done), .err(err), .cnt_out(cnt_out), .cnt_in(cnt_in), .up_dn(up_dn),
    .ena(ena), .cnt_load(cnt_load), .s_reset(s_reset)
  );

  // updn_cntr stand-in: sync clear, active-low load, enabled up/down count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       cnt_out <= '0;
    else if (s_reset)   cnt_out <= '0;
    else if (!cnt_load) cnt_out <= cnt_in;
    else if (ena)       cnt_out <= up_dn ? cnt_out + 8'd1 : cnt_out - 8'd1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  // Counter value t edges after accept for an uninterrupted sweep.
  function automatic int tri_val(int lo, int d, int laps, int t);
    int p;
    if (t >= 2*d*laps + 1) return lo;
    p = (t - 1) % (2*d);
    return (p <= d) ? lo + p : lo + 2*d - p;
  endfunction

  task automatic run(input int lo, input int hi, input int laps, input int abort_at,
                     input int p_at, input int p_len, input bit junk);
    int L, d, t_done, e, ex;
    L = (laps == 0) ? 1 : laps;
    d = hi - lo;
    cmd_lo = 8'(lo); cmd_hi = 8'(hi); cmd_laps = 4'(laps); cmd_valid = 1'b1;
    chk("ready_pre", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = junk;
    if (junk) begin
      cmd_lo = 8'($urandom); cmd_hi = 8'($urandom); cmd_laps = 4'($urandom);
    end
    if (lo >= hi) begin
      cmd_valid = 1'b0;
      chk("bad_done", done, 1);
      chk("bad_err", err, 1);
      chk("bad_ena", ena, 0);
      chk("bad_load", cnt_load, 1);
      @(posedge clk); #1;
      chk("bad_cnt", cnt_out, m_cnt);
      chk("bad_ready", cmd_ready, 1);
      chk("bad_done_clr", done, 0);
      return;
    end
    chk("busy_ready", cmd_ready, 0);
    chk("load_pin", cnt_load, 0);
    chk("load_data", cnt_in, lo);
    chk("load_done", done, 0);
    if (abort_at == 0) abort = 1'b1;
    t_done = (abort_at >= 0) ? abort_at + 2 : 2*d*L + 2 + ((p_at >= 0) ? p_len : 0);
    for (int t = 1; t <= t_done; t++) begin
      @(posedge clk); #1;
      e = t;
      if (p_at >= 0 && t > p_at) e = t - ((t - p_at < p_len) ? t - p_at : p_len);
      ex = (abort_at >= 0 && t == abort_at + 2) ? 0 : tri_val(lo, d, L, e);
      chk("cnt", cnt_out, ex);
      chk("done", done, (t == t_done));
      if (t == t_done) chk("err", err, (abort_at >= 0));
      if (abort_at >= 0 && t == abort_at + 1) chk("s_reset", s_reset, 1);
      abort = (t == abort_at);
`ifdef SWEEP_PAUSE_EN
      pause = (p_at >= 0 && t >= p_at && t < p_at + p_len);
`endif
      if (t == t_done) cmd_valid = 1'b0;
    end
    abort = 1'b0;
    @(posedge clk); #1;
    chk("ready_post", cmd_ready, 1);
    chk("done_post", done, 0);
    m_cnt = (abort_at >= 0) ? 0 : lo;
  endtask

  initial begin
    int lo, hi, laps, d, ab, pa, pl, seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ena", ena, 0);
    chk("rst_load", cnt_load, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_srst", s_reset, 0);
    chk("rst_updn", up_dn, 1);
    chk("rst_cntin", cnt_in, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_ready", cmd_ready, 1);
    chk("idle_abort_srst", s_reset, 0);
    chk("idle_abort_done", done, 0);

    run(2, 5, 1, -1, -1, 0, 0);
    run(10, 12, 3, -1, -1, 0, 0);
    run(7, 7, 1, -1, -1, 0, 0);
    run(0, 255, 1, 101, -1, 0, 0);
    run(250, 255, 0, -1, -1, 0, 1);
    run(9, 3, 2, -1, -1, 0, 1);
`ifdef SWEEP_PAUSE_EN
    run(2, 5, 1, -1, 3, 3, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      lo = $urandom_range(0, 250);
      if ($urandom_range(0, 5) == 0) hi = $urandom_range(0, lo);
      else hi = lo + $urandom_range(1, 5);
      laps = $urandom_range(0, 15);
      d = (hi > lo) ? hi - lo : 0;
      ab = -1; pa = -1; pl = 0;
      if (d > 0 && $urandom_range(0, 2) == 0)
        ab = $urandom_range(0, 2*d*((laps == 0) ? 1 : laps) + 1);
`ifdef SWEEP_PAUSE_EN
      else if (d > 0 && $urandom_range(0, 1) == 0) begin
        pa = $urandom_range(1, 2*d*((laps == 0) ? 1 : laps));
        pl = $urandom_range(1, 4);
      end
`endif
      run(lo, hi, laps, ab, pa, pl, 1'($urandom_range(0, 1)));
    end

    // Reset mid-sweep returns to idle without a done pulse.
    cmd_lo = 8'd1; cmd_hi = 8'd9; cmd_laps = 4'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_ena", ena, 0);
    chk("mid_rst_cnt", cnt_out, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    chk("mid_rst_idle", cmd_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 want 0");
    $fatal(1, "bench time limit");
  end
endmodule
